// File: rtl/bench_event_gen.sv
// bench_event_gen: turns an accepted valid/ready transaction stream into spaced
// benchmark event pulses and raises a sticky end-of-simulation request on a limit.
module bench_event_gen #(
    parameter int unsigned TXN_PER_EVENT = 16,
    parameter int unsigned PULSE_W       = 2,
    parameter int unsigned HOLDOFF       = 4,
    parameter int unsigned MAX_EVENTS    = 0,
    parameter int unsigned CLK_LIMIT     = 200000,
    parameter int unsigned CNT_W         = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic             txn_valid_i,
    output logic             txn_ready_o,
    output logic             benchmark_event_o,
    output logic [CNT_W-1:0] event_cnt_o,
    output logic [CNT_W-1:0] txn_cnt_o,
    output logic [CNT_W-1:0] clk_cnt_o,
    output logic             eos_o,
    output logic             busy_o
);

    localparam int unsigned WIN_W   = $clog2(TXN_PER_EVENT + 1);
    localparam int unsigned TMR_MAX = (PULSE_W > HOLDOFF) ? PULSE_W : HOLDOFF;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(TXN_PER_EVENT - 1);
    localparam logic [TMR_W-1:0] PULSE_LD  = TMR_W'(PULSE_W - 1);
    localparam logic [TMR_W-1:0] HOLD_LD   = TMR_W'(HOLDOFF - 1);
    localparam logic [CNT_W-1:0] CLK_LIM_C = CNT_W'(CLK_LIMIT);
    localparam logic [CNT_W-1:0] MAX_EV_C  = CNT_W'(MAX_EVENTS);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COUNT   = 3'd1,
        S_PULSE   = 3'd2,
        S_HOLDOFF = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t           state_r;
    logic [WIN_W-1:0] win_r;
    logic [TMR_W-1:0] timer_r;
    logic             pend_r;

    logic             accept_s;
    logic             win_full_s;
    logic             pend_now_s;
    logic [CNT_W-1:0] clk_inc_s;
    logic             limit_hit_s;
    logic             lim_nxt_s;
    logic             max_hit_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        sat_inc = (&v) ? v : v + CNT_W'(1);
    endfunction

    // Handshake, window and limit decode feeding the state machine.
    always_comb begin
        accept_s    = txn_valid_i & txn_ready_o;
        win_full_s  = accept_s & (win_r == WIN_LAST);
        pend_now_s  = pend_r | win_full_s;
        clk_inc_s   = sat_inc(clk_cnt_o);
        limit_hit_s = (CLK_LIMIT != 32'd0) && (clk_cnt_o == CLK_LIM_C);
        lim_nxt_s   = (CLK_LIMIT != 32'd0) && (clk_inc_s == CLK_LIM_C);
        max_hit_s   = (MAX_EVENTS != 32'd0) && (event_cnt_o == MAX_EV_C);
    end

    // State machine, counters and registered outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r           <= S_IDLE;
            win_r             <= {WIN_W{1'b0}};
            timer_r           <= {TMR_W{1'b0}};
            pend_r            <= 1'b0;
            txn_ready_o       <= 1'b0;
            benchmark_event_o <= 1'b0;
            event_cnt_o       <= {CNT_W{1'b0}};
            txn_cnt_o         <= {CNT_W{1'b0}};
            clk_cnt_o         <= {CNT_W{1'b0}};
            eos_o             <= 1'b0;
            busy_o            <= 1'b0;
        end else if (state_r == S_DONE) begin
            state_r <= S_DONE;
        end else if (limit_hit_s) begin
            // Clock limit overrides everything, truncating any pulse.
            state_r           <= S_DONE;
            eos_o             <= 1'b1;
            txn_ready_o       <= 1'b0;
            benchmark_event_o <= 1'b0;
            busy_o            <= 1'b0;
        end else begin
            clk_cnt_o <= clk_inc_s;
            if (accept_s) begin
                txn_cnt_o <= sat_inc(txn_cnt_o);
                win_r     <= win_r + WIN_W'(1);
            end
            case (state_r)
                S_IDLE: begin
                    if (enable_i) begin
                        state_r     <= S_COUNT;
                        txn_ready_o <= ~lim_nxt_s;
                    end
                end
                S_COUNT: begin
                    if (win_full_s) begin
                        state_r           <= S_PULSE;
                        timer_r           <= PULSE_LD;
                        win_r             <= {WIN_W{1'b0}};
                        event_cnt_o       <= sat_inc(event_cnt_o);
                        benchmark_event_o <= 1'b1;
                        busy_o            <= 1'b1;
                        txn_ready_o       <= ~lim_nxt_s;
                    end else if (!enable_i) begin
                        state_r     <= S_IDLE;
                        txn_ready_o <= 1'b0;
                    end else begin
                        txn_ready_o <= ~lim_nxt_s;
                    end
                end
                S_PULSE, S_HOLDOFF: begin
                    if (win_full_s) begin
                        pend_r <= 1'b1;
                    end
                    // A full window waiting for its pulse stalls the upstream.
                    txn_ready_o <= ~pend_now_s & ~lim_nxt_s;
                    if (timer_r != {TMR_W{1'b0}}) begin
                        timer_r <= timer_r - TMR_W'(1);
                    end else if (state_r == S_PULSE && HOLDOFF != 32'd0) begin
                        state_r           <= S_HOLDOFF;
                        timer_r           <= HOLD_LD;
                        benchmark_event_o <= 1'b0;
                    end else if (max_hit_s) begin
                        state_r           <= S_DONE;
                        eos_o             <= 1'b1;
                        txn_ready_o       <= 1'b0;
                        benchmark_event_o <= 1'b0;
                        busy_o            <= 1'b0;
                    end else if (pend_now_s) begin
                        state_r           <= S_PULSE;
                        timer_r           <= PULSE_LD;
                        win_r             <= {WIN_W{1'b0}};
                        pend_r            <= 1'b0;
                        event_cnt_o       <= sat_inc(event_cnt_o);
                        benchmark_event_o <= 1'b1;
                        busy_o            <= 1'b1;
                        txn_ready_o       <= ~lim_nxt_s;
                    end else if (!enable_i) begin
                        state_r           <= S_IDLE;
                        benchmark_event_o <= 1'b0;
                        busy_o            <= 1'b0;
                        txn_ready_o       <= 1'b0;
                    end else begin
                        state_r           <= S_COUNT;
                        benchmark_event_o <= 1'b0;
                        busy_o            <= 1'b0;
                        txn_ready_o       <= ~lim_nxt_s;
                    end
                end
                default: begin
                    state_r           <= S_IDLE;
                    txn_ready_o       <= 1'b0;
                    benchmark_event_o <= 1'b0;
                    busy_o            <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bench_event_gen.sv
// Bench for bench_event_gen: directed vector table, hand sequences for the
// limit corners, and randomized stimulus against a behavioural model.
module tb_bench_event_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, en = 1'b0, val = 1'b0;

    logic       a_rdy, a_ev, a_eos, a_busy;
    logic [7:0] a_evc, a_txc, a_clc;
    logic        m_rdy, m_ev, m_eos, m_busy;
    logic [31:0] m_evc, m_txc, m_clc;
    logic        c_rdy, c_ev, c_eos, c_busy;
    logic [31:0] c_evc, c_txc, c_clc;

    bench_event_gen #(.TXN_PER_EVENT(4), .PULSE_W(2), .HOLDOFF(4), .MAX_EVENTS(0),
                      .CLK_LIMIT(0), .CNT_W(8)) dut_a (
        .clk_i(clk), .reset_i(rst), .enable_i(en), .txn_valid_i(val),
        .txn_ready_o(a_rdy), .benchmark_event_o(a_ev), .event_cnt_o(a_evc),
        .txn_cnt_o(a_txc), .clk_cnt_o(a_clc), .eos_o(a_eos), .busy_o(a_busy));

    bench_event_gen #(.TXN_PER_EVENT(4), .PULSE_W(2), .HOLDOFF(4), .MAX_EVENTS(3),
                      .CLK_LIMIT(0), .CNT_W(32)) dut_m (
        .clk_i(clk), .reset_i(rst), .enable_i(en), .txn_valid_i(val),
        .txn_ready_o(m_rdy), .benchmark_event_o(m_ev), .event_cnt_o(m_evc),
        .txn_cnt_o(m_txc), .clk_cnt_o(m_clc), .eos_o(m_eos), .busy_o(m_busy));

    bench_event_gen #(.TXN_PER_EVENT(4), .PULSE_W(3), .HOLDOFF(4), .MAX_EVENTS(0),
                      .CLK_LIMIT(20), .CNT_W(32)) dut_c (
        .clk_i(clk), .reset_i(rst), .enable_i(en), .txn_valid_i(val),
        .txn_ready_o(c_rdy), .benchmark_event_o(c_ev), .event_cnt_o(c_evc),
        .txn_cnt_o(c_txc), .clk_cnt_o(c_clc), .eos_o(c_eos), .busy_o(c_busy));

    typedef struct packed {
        logic        rdy, ev, eos, busy;
        logic [31:0] evc, txc, clc;
    } obs_t;

    typedef struct {
        int     n, pw, ho, maxe, lim, cw;
        int     mode;              // 0 = stopped, 1 = counting
        bit     done, pend, ready;
        int     pulse_left, hold_left, win;
        longint evc, txc, clc;
    } model_t;

    typedef struct {
        bit r, e, v;
        bit rdy, ev, eos, busy;
        int evc, txc, clc;
    } vec_t;

    int total = 0;
    int bad   = 0;
    model_t ma, mm, mc;
    vec_t   tbl[$];

    function automatic longint sat(input longint x, input int cw);
        longint cmax = (longint'(1) << cw) - 64'sd1;
        return (x >= cmax) ? cmax : x + 64'sd1;
    endfunction

    // One clock of the reference behaviour, inputs as seen before the edge.
    function automatic model_t step(input model_t mi, input bit r, input bit e, input bit v);
        model_t m = mi;
        bit acc, full, leaving;
        if (r) begin
            m.mode = 0; m.done = 1'b0; m.pend = 1'b0;
            m.pulse_left = 0; m.hold_left = 0; m.win = 0;
            m.evc = 0; m.txc = 0; m.clc = 0;
        end else if (m.done) begin
            m.done = 1'b1;
        end else if (m.lim != 0 && m.clc == longint'(m.lim)) begin
            m.done = 1'b1; m.pulse_left = 0; m.hold_left = 0;
        end else begin
            acc = v && m.ready;
            m.clc = sat(m.clc, m.cw);
            if (acc) begin
                m.txc = sat(m.txc, m.cw);
                m.win++;
            end
            full = acc && (m.win == m.n);
            if (m.pulse_left > 0 || m.hold_left > 0) begin
                if (full) m.pend = 1'b1;
                leaving = 1'b0;
                if (m.pulse_left > 0) begin
                    m.pulse_left--;
                    if (m.pulse_left == 0) begin
                        if (m.ho > 0) m.hold_left = m.ho;
                        else leaving = 1'b1;
                    end
                end else begin
                    m.hold_left--;
                    leaving = (m.hold_left == 0);
                end
                if (leaving) begin
                    if (m.maxe != 0 && m.evc == longint'(m.maxe)) m.done = 1'b1;
                    else if (m.pend) begin
                        m.pend = 1'b0; m.win = 0;
                        m.evc = sat(m.evc, m.cw); m.pulse_left = m.pw;
                    end else m.mode = e ? 1 : 0;
                end
            end else if (m.mode == 1) begin
                if (full) begin
                    m.win = 0; m.evc = sat(m.evc, m.cw); m.pulse_left = m.pw;
                end else if (!e) m.mode = 0;
            end else if (e) m.mode = 1;
        end
        m.ready = !m.done && !(m.lim != 0 && m.clc == longint'(m.lim)) &&
                  ((m.pulse_left > 0 || m.hold_left > 0) ? !m.pend : (m.mode == 1));
        return m;
    endfunction

    function automatic obs_t obs_of(input model_t m);
        obs_t o;
        o.rdy = m.ready; o.ev = (m.pulse_left > 0); o.eos = m.done;
        o.busy = (m.pulse_left > 0) || (m.hold_left > 0);
        o.evc = 32'(m.evc); o.txc = 32'(m.txc); o.clc = 32'(m.clc);
        return o;
    endfunction

    function automatic obs_t get_a();
        return {a_rdy, a_ev, a_eos, a_busy, 24'd0, a_evc, 24'd0, a_txc, 24'd0, a_clc};
    endfunction
    function automatic obs_t get_m();
        return {m_rdy, m_ev, m_eos, m_busy, m_evc, m_txc, m_clc};
    endfunction
    function automatic obs_t get_c();
        return {c_rdy, c_ev, c_eos, c_busy, c_evc, c_txc, c_clc};
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got rdy=%0b ev=%0b eos=%0b busy=%0b evc=%0d txc=%0d clk=%0d required rdy=%0b ev=%0b eos=%0b busy=%0b evc=%0d txc=%0d clk=%0d",
                     name, got.rdy, got.ev, got.eos, got.busy, got.evc, got.txc, got.clc,
                     exp.rdy, exp.ev, exp.eos, exp.busy, exp.evc, exp.txc, exp.clc);
        end
    endtask

    task automatic check_val(input string name, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    // Apply one cycle of stimulus and compare every instance with its model.
    task automatic tick(input bit r, input bit e, input bit v);
        rst = r; en = e; val = v;
        ma = step(ma, r, e, v);
        mm = step(mm, r, e, v);
        mc = step(mc, r, e, v);
        @(posedge clk);
        #1;
        check("model_a", get_a(), obs_of(ma));
        check("model_m", get_m(), obs_of(mm));
        check("model_c", get_c(), obs_of(mc));
    endtask

    task automatic add(input bit r, e, v, rdy, ev, eos, busy, input int evc, txc, clc);
        vec_t t;
        t.r = r; t.e = e; t.v = v; t.rdy = rdy; t.ev = ev; t.eos = eos; t.busy = busy;
        t.evc = evc; t.txc = txc; t.clc = clc;
        tbl.push_back(t);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        obs_t exp;
        ma = '{n:4, pw:2, ho:4, maxe:0, lim:0,  cw:8,  default:0};
        mm = '{n:4, pw:2, ho:4, maxe:3, lim:0,  cw:32, default:0};
        mc = '{n:4, pw:3, ho:4, maxe:0, lim:20, cw:32, default:0};

        // Basic event, pending stall, reset in holdoff, enable toggle (dut_a).
        add(1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 0, 0, 0);
        add(1'b0,1'b1,1'b1, 1'b1,1'b0,1'b0,1'b0, 0, 0, 1);
        add(1'b0,1'b1,1'b1, 1'b1,1'b0,1'b0,1'b0, 0, 1, 2);
        add(1'b0,1'b1,1'b1, 1'b1,1'b0,1'b0,1'b0, 0, 2, 3);
        add(1'b0,1'b1,1'b1, 1'b1,1'b0,1'b0,1'b0, 0, 3, 4);
        add(1'b0,1'b1,1'b1, 1'b1,1'b1,1'b0,1'b1, 1, 4, 5);
        add(1'b0,1'b1,1'b1, 1'b1,1'b1,1'b0,1'b1, 1, 5, 6);
        add(1'b0,1'b1,1'b1, 1'b1,1'b0,1'b0,1'b1, 1, 6, 7);
        add(1'b0,1'b1,1'b1, 1'b1,1'b0,1'b0,1'b1, 1, 7, 8);
        add(1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b1, 1, 8, 9);
        add(1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b1, 1, 8, 10);
        add(1'b0,1'b1,1'b1, 1'b1,1'b1,1'b0,1'b1, 2, 8, 11);
        add(1'b0,1'b1,1'b1, 1'b1,1'b1,1'b0,1'b1, 2, 9, 12);
        add(1'b0,1'b1,1'b1, 1'b1,1'b0,1'b0,1'b1, 2, 10, 13);
        add(1'b1,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0, 0, 0, 0);
        add(1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0, 0, 0, 1);
        add(1'b0,1'b1,1'b1, 1'b1,1'b0,1'b0,1'b0, 0, 0, 2);
        add(1'b0,1'b1,1'b1, 1'b1,1'b0,1'b0,1'b0, 0, 1, 3);
        add(1'b0,1'b1,1'b1, 1'b1,1'b0,1'b0,1'b0, 0, 2, 4);
        add(1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 0, 2, 5);
        for (int k = 0; k < 10; k++)
            add(1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0, 0, 2, 6 + k);
        add(1'b0,1'b1,1'b1, 1'b1,1'b0,1'b0,1'b0, 0, 2, 16);
        add(1'b0,1'b1,1'b1, 1'b1,1'b0,1'b0,1'b0, 0, 3, 17);
        add(1'b0,1'b1,1'b1, 1'b1,1'b1,1'b0,1'b1, 1, 4, 18);

        for (int i = 0; i < tbl.size(); i++) begin
            tick(tbl[i].r, tbl[i].e, tbl[i].v);
            exp.rdy = tbl[i].rdy; exp.ev = tbl[i].ev; exp.eos = tbl[i].eos;
            exp.busy = tbl[i].busy; exp.evc = 32'(tbl[i].evc);
            exp.txc = 32'(tbl[i].txc); exp.clc = 32'(tbl[i].clc);
            check($sformatf("vec%0d", i), get_a(), exp);
        end

        // Continuous traffic from reset: MAX_EVENTS on dut_m, CLK_LIMIT mid-pulse on dut_c.
        tick(1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 30; i++) begin
            tick(1'b0, 1'b1, 1'b1);
            if (i == 17) check_val("a_third_pulse", a_ev, 1);
            if (i == 20) begin
                check_val("c_mid_pulse_ev", c_ev, 1);
                check_val("c_mid_pulse_clk", c_clc, 20);
                check_val("c_mid_pulse_evc", c_evc, 3);
            end
            if (i == 21) begin
                check_val("c_limit_ev_drop", c_ev, 0);
                check_val("c_limit_eos", c_eos, 1);
                check_val("c_limit_ready", c_rdy, 0);
            end
            if (i == 22) check_val("m_eos_before_end", m_eos, 0);
            if (i == 23) begin
                check_val("m_max_eos", m_eos, 1);
                check_val("m_max_ready", m_rdy, 0);
                check_val("m_max_evc", m_evc, 3);
                check_val("m_max_txc", m_txc, 16);
            end
        end
        check_val("c_clk_frozen", c_clc, 20);
        check_val("c_eos_sticky", c_eos, 1);
        check_val("m_evc_frozen", m_evc, 3);
        check_val("m_txc_frozen", m_txc, 16);

        // Long random run without reset so the narrow counters of dut_a saturate.
        tick(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2500; i++)
            tick(1'b0, $urandom_range(0, 15) != 0, $urandom_range(0, 3) != 0);
        check_val("a_clk_saturated", a_clc, 255);

        // Random run with occasional resets.
        for (int i = 0; i < 1500; i++)
            tick($urandom_range(0, 39) == 0, $urandom_range(0, 7) != 0,
                 $urandom_range(0, 2) != 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bench_event_gen.md
# bench_event_gen

Transaction-to-benchmark-event stage inside the target RTL, directly upstream of the simulation top's benchmark counter. It accepts a valid/ready transaction stream from the LT target, counts completed transactions, and emits a clean, separated `benchmark_event_o` pulse every `TXN_PER_EVENT` transactions. It also tracks clocks and events and raises a sticky end-of-simulation request when either limit is reached.

## Interface
Parameters:
- `TXN_PER_EVENT`, 16: accepted transactions per benchmark event; must be ≥1.
- `PULSE_W`, 2: cycles `benchmark_event_o` stays high; must be ≥1.
- `HOLDOFF`, 4: low cycles forced after each pulse; 0 means no holdoff.
- `MAX_EVENTS`, 0: event count that triggers end of simulation; 0 means unlimited.
- `CLK_LIMIT`, 200000: clock count that triggers end of simulation; 0 means none.
- `CNT_W`, 32: width of the counters.

Ports:
- `clk_i`  in  1  single clock, rising edge.
- `reset_i`  in  1  synchronous, active-high reset.
- `enable_i`  in  1  run enable.
- `txn_valid_i`  in  1  upstream transaction valid.
- `txn_ready_o`  out  1  transaction accept.
- `benchmark_event_o`  out  1  event pulse.
- `event_cnt_o`  out  CNT_W  events emitted.
- `txn_cnt_o`  out  CNT_W  total transactions accepted.
- `clk_cnt_o`  out  CNT_W  cycles since reset.
- `eos_o`  out  1  sticky end-of-simulation request.
- `busy_o`  out  1  high in PULSE or HOLDOFF.

## Operation
- **Reset:** state IDLE. All outputs and counters are 0, including the window counter, pulse/holdoff timers and the pending flag.
- **Handshake:** a transaction is accepted on any cycle where `txn_valid_i & txn_ready_o` is high. Accepting increments `txn_cnt_o` and the window counter `win`. All counters saturate at all-ones.
- **`clk_cnt_o`:** increments every cycle outside reset until DONE, then holds.
- **IDLE:** `txn_ready_o` = 0. `enable_i` = 1 moves to COUNT on the next cycle.
- **COUNT:** `txn_ready_o` = 1.
  - The accept that makes `win` equal `TXN_PER_EVENT` moves to PULSE. On that same edge `win` clears and `event_cnt_o` increments.
  - `enable_i` = 0 moves to IDLE. `win` and all counters are retained.
- **PULSE:** `benchmark_event_o` = 1 for exactly `PULSE_W` cycles. Accepting continues into the new window.
  - If `win` reaches `TXN_PER_EVENT` here or in HOLDOFF, the pending flag is set and `txn_ready_o` drops until the pending event is issued. Only one event can be pending.
- **HOLDOFF:** `benchmark_event_o` = 0 for `HOLDOFF` cycles. The state is skipped when `HOLDOFF` = 0.
- **On exit from PULSE/HOLDOFF, first match wins:**
  1. `MAX_EVENTS` ≠ 0 and `event_cnt_o` == `MAX_EVENTS`: go to DONE.
  2. Pending flag set: go to PULSE. `event_cnt_o` increments, `win` clears, pending clears.
  3. `enable_i` = 0: go to IDLE.
  4. Otherwise: go to COUNT.
- **`enable_i` drop during PULSE/HOLDOFF:** the pulse and holdoff still complete.
- **CLK_LIMIT:** when `CLK_LIMIT` ≠ 0 and `clk_cnt_o` == `CLK_LIMIT`, go to DONE from any state on the next edge. This takes precedence over every other transition. A pulse in progress is truncated, so `benchmark_event_o` is 0 in DONE.
- **DONE:** `eos_o` = 1, `txn_ready_o` = 0, all counters frozen. Only `reset_i` exits DONE.
- **Reset mid-operation:** returns everything to reset values on the next edge. Any pulse in progress is dropped.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- **Event latency:** the accept that completes a window at edge k raises `benchmark_event_o` from edge k+1 through edge k+`PULSE_W`. `event_cnt_o` updates at edge k+1.
- **Event spacing:** minimum distance between rising edges of `benchmark_event_o` is `PULSE_W`+`HOLDOFF` cycles. A back-to-back pending event rises at edge k+`PULSE_W`+`HOLDOFF`+1.
- **Accept timing:** `txn_ready_o` asserts one cycle after `enable_i` rises. It deasserts on the edge where the pending flag is set.
- `eos_o` asserts the cycle after the terminating condition and then stays high.

## Test plan
- **Basic event:** N=4, PULSE_W=2, HOLDOFF=4; `txn_valid_i` held high from cycle 0 with enable. Required: first pulse 2 cycles wide, rising the cycle after the 4th accept; `event_cnt_o` = 1; `txn_cnt_o` keeps incrementing through PULSE.
- **Pending and stall:** same parameters, continuous valid. Required: the second window fills during HOLDOFF, `txn_ready_o` drops, and the second pulse rises exactly 6 cycles after the first; no transaction is lost (`txn_cnt_o` = 8 at the second pulse).
- **MAX_EVENTS:** MAX_EVENTS=3. Required: after the 3rd pulse and holdoff, `eos_o` = 1, `txn_ready_o` = 0, `event_cnt_o` frozen at 3; further valids are ignored.
- **CLK_LIMIT during pulse:** CLK_LIMIT=20, timed so the limit hits mid-pulse. Required: `benchmark_event_o` drops on the next edge, `eos_o` = 1, `clk_cnt_o` frozen at 20.
- **Enable toggle:** drop `enable_i` after 2 accepts (N=4), wait 10 cycles, re-enable. Required: `txn_ready_o` low while disabled; the pulse fires after 2 more accepts.
- **Reset mid-operation:** assert `reset_i` during HOLDOFF. Required: next cycle all outputs 0 and state IDLE; normal operation resumes after reset is released.
